// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the coprocessor offload queue.
package cv32e40x_pkg;

  // Lifecycle of one in-flight queue entry
  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2,
    ENTRY_KILLED    = 2'd3
  } entry_state_e;

  // Payload held per entry; the offload id is kept alongside because its width is a parameter
  typedef struct packed {
    entry_state_e state;
    logic [4:0]   rd;
    logic [31:0]  data;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{state: ENTRY_FREE, rd: 5'd0, data: 32'd0};

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] FUNCT3_ADD     = 3'b000;
  localparam logic [2:0] FUNCT3_SUB     = 3'b001;
  localparam logic [6:0] FUNCT7_ZERO    = 7'b0000000;

  // True when the instruction is in the custom-0 space with a zero funct7 and the given funct3
  function automatic logic match_op(input logic [31:0] instr, input logic [2:0] funct3);
    return (instr[6:0] == OPCODE_CUSTOM0) && (instr[14:12] == funct3) &&
           (instr[31:25] == FUNCT7_ZERO);
  endfunction

endpackage

// File: rtl/if_xif.sv
// Coprocessor extension interface: issue, commit and result channels.
interface if_xif #(
  parameter int X_ID_WIDTH = 4
);
  // Issue channel
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_req_instr;
  logic [1:0][31:0]      issue_req_rs;
  logic [1:0]            issue_req_rs_valid;
  logic [X_ID_WIDTH-1:0] issue_req_id;
  logic                  issue_resp_accept;
  logic                  issue_resp_writeback;
  logic                  issue_resp_dualwrite;
  logic                  issue_resp_dualread;
  logic                  issue_resp_loadstore;
  logic                  issue_resp_exc;

  // Commit channel
  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  // Result channel
  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [4:0]            result_rd;
  logic [31:0]           result_data;
  logic                  result_we;
  logic                  result_exc;
  logic [5:0]            result_exccode;

  modport coproc_issue (
    input  issue_valid, issue_req_instr, issue_req_rs, issue_req_rs_valid, issue_req_id,
    output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_dualwrite,
           issue_resp_dualread, issue_resp_loadstore, issue_resp_exc
  );

  modport coproc_commit (
    input commit_valid, commit_id, commit_kill
  );

  modport coproc_result (
    input  result_ready,
    output result_valid, result_id, result_rd, result_data, result_we, result_exc,
           result_exccode
  );
endinterface

// File: rtl/xif_coproc_alu.sv
// 32-bit add/subtract datapath for offloaded instructions.
module xif_coproc_alu (
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic [31:0] result
);

  // Wrap-around arithmetic, result truncated to 32 bits
  assign result = sub ? (op_a - op_b) : (op_a + op_b);

endmodule

// File: rtl/xif_coproc_queue.sv
// In-order coprocessor offload queue: accepts custom-0 ADD instructions, waits
// for commit or kill per id, and returns results strictly in issue order.
// Build option: define XIF_COPROC_SUB_EN to also accept the SUB variant (funct3=001).
module xif_coproc_queue
  import cv32e40x_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input logic          clk,
  input logic          rst,
  if_xif.coproc_issue  xif_issue,
  if_xif.coproc_commit xif_commit,
  if_xif.coproc_result xif_result
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t                entries_reg [DEPTH];
  entry_t                entries_next[DEPTH];
  logic [X_ID_WIDTH-1:0] ids_reg     [DEPTH];
  logic [X_ID_WIDTH-1:0] ids_next    [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic                  result_valid_reg, result_valid_next;
  logic [X_ID_WIDTH-1:0] result_id_reg, result_id_next;
  logic [4:0]            result_rd_reg, result_rd_next;
  logic [31:0]           result_data_reg, result_data_next;

  logic [31:0]      instr;
  logic             is_add;
  logic             is_sub;
  logic             recognised;
  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      alu_result;
  logic [DEPTH-1:0] commit_hit;
  logic             unused_instr_bits;

  assign instr             = xif_issue.issue_req_instr;
  assign unused_instr_bits = ^instr[24:15];

  assign is_add = match_op(instr, FUNCT3_ADD);
`ifdef XIF_COPROC_SUB_EN
  assign is_sub = match_op(instr, FUNCT3_SUB);
`else
  assign is_sub = 1'b0;
`endif
  assign recognised = is_add | is_sub;

  assign full = (count_reg == CNT_W'(DEPTH));

  // Only accepted instructions occupy a slot, so only they are throttled by a full queue
  assign xif_issue.issue_ready = !rst &&
      (!recognised || (!full && (xif_issue.issue_req_rs_valid == 2'b11)));

  assign xif_issue.issue_resp_accept    = recognised;
  assign xif_issue.issue_resp_writeback = recognised;
  assign xif_issue.issue_resp_dualwrite = 1'b0;
  assign xif_issue.issue_resp_dualread  = 1'b0;
  assign xif_issue.issue_resp_loadstore = 1'b0;
  assign xif_issue.issue_resp_exc       = 1'b0;

  assign push = xif_issue.issue_valid && xif_issue.issue_ready && recognised;

  // A committed head leaves on the result handshake; a killed head is dropped silently
  assign pop = (result_valid_reg && xif_result.result_ready) ||
               (entries_reg[head_reg].state == ENTRY_KILLED);

  xif_coproc_alu u_alu (
    .op_a   (xif_issue.issue_req_rs[0]),
    .op_b   (xif_issue.issue_req_rs[1]),
    .sub    (is_sub),
    .result (alu_result)
  );

  // Commit matches only entries already waiting, so an id allocated this cycle is never hit
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_commit_hit
      assign commit_hit[gi] = xif_commit.commit_valid &&
                              (entries_reg[gi].state == ENTRY_ISSUED) &&
                              (ids_reg[gi] == xif_commit.commit_id);
    end
  endgenerate

  // Next-state of every entry: allocate at tail, resolve commits, release the head
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_next[i] = entries_reg[i];
      ids_next[i]     = ids_reg[i];
      if (push && (tail_reg == PTR_W'(i))) begin
        entries_next[i].state = ENTRY_ISSUED;
        entries_next[i].rd    = instr[11:7];
        entries_next[i].data  = alu_result;
        ids_next[i]           = xif_issue.issue_req_id;
      end else if (commit_hit[i]) begin
        entries_next[i].state = xif_commit.commit_kill ? ENTRY_KILLED : ENTRY_COMMITTED;
      end else if (pop && (head_reg == PTR_W'(i))) begin
        entries_next[i] = ENTRY_RESET;
      end
    end
  end

  // Pointer/count updates and the registered view of the next head entry
  always_comb begin
    head_next  = head_reg + PTR_W'(pop);
    tail_next  = tail_reg + PTR_W'(push);
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    result_valid_next = (entries_next[head_next].state == ENTRY_COMMITTED);
    result_id_next    = '0;
    result_rd_next    = '0;
    result_data_next  = '0;
    if (result_valid_next) begin
      result_id_next   = ids_next[head_next];
      result_rd_next   = entries_next[head_next].rd;
      result_data_next = entries_next[head_next].data;
    end
  end

  // State registers; reset discards every in-flight entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= ENTRY_RESET;
        ids_reg[i]     <= '0;
      end
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      result_valid_reg <= 1'b0;
      result_id_reg    <= '0;
      result_rd_reg    <= '0;
      result_data_reg  <= '0;
    end else begin
      entries_reg      <= entries_next;
      ids_reg          <= ids_next;
      head_reg         <= head_next;
      tail_reg         <= tail_next;
      count_reg        <= count_next;
      result_valid_reg <= result_valid_next;
      result_id_reg    <= result_id_next;
      result_rd_reg    <= result_rd_next;
      result_data_reg  <= result_data_next;
    end
  end

  assign xif_result.result_valid   = result_valid_reg;
  assign xif_result.result_id      = result_id_reg;
  assign xif_result.result_rd      = result_rd_reg;
  assign xif_result.result_data    = result_data_reg;
  assign xif_result.result_we      = 1'b1;
  assign xif_result.result_exc     = 1'b0;
  assign xif_result.result_exccode = 6'd0;

endmodule

// File: tb/tb_xif_coproc_queue.sv
// Directed bench for xif_coproc_queue with an in-order queue model checked every cycle.
module tb_xif_coproc_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
`ifdef XIF_COPROC_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int ST_ISS  = 1;
  localparam int ST_COM  = 2;
  localparam int ST_KILL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_xif #(.X_ID_WIDTH(IDW)) xif ();

  xif_coproc_queue #(.X_ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .xif_issue  (xif),
    .xif_commit (xif),
    .xif_result (xif)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [4:0]     rd;
    logic [31:0]    data;
    int             st;
  } ment_t;
  ment_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_recog(input logic [31:0] ins);
    bit base;
    base = (ins[6:0] == 7'b0001011) && (ins[31:25] == 7'd0);
    return base && ((ins[14:12] == 3'b000) || (SUB_EN && ins[14:12] == 3'b001));
  endfunction

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (!m_recog(xif.issue_req_instr)) return 1'b1;
    return (mq.size() < DEPTH) && (xif.issue_req_rs_valid == 2'b11);
  endfunction

  // Model transition from the inputs present at a rising edge
  task automatic model_step();
    bit    do_push;
    bit    do_pop;
    ment_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    do_push = xif.issue_valid && m_ready() && m_recog(xif.issue_req_instr);
    do_pop  = (mq.size() > 0) &&
              ((mq[0].st == ST_COM && xif.result_ready) || mq[0].st == ST_KILL);
    if (xif.commit_valid)
      foreach (mq[i])
        if (mq[i].st == ST_ISS && mq[i].id == xif.commit_id)
          mq[i].st = xif.commit_kill ? ST_KILL : ST_COM;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.id   = xif.issue_req_id;
      e.rd   = xif.issue_req_instr[11:7];
      e.data = (xif.issue_req_instr[14:12] == 3'b001) ?
               xif.issue_req_rs[0] - xif.issue_req_rs[1] :
               xif.issue_req_rs[0] + xif.issue_req_rs[1];
      e.st   = ST_ISS;
      mq.push_back(e);
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (mq.size() > 0) && (mq[0].st == ST_COM);
    chk("result_valid", 32'(xif.result_valid), 32'(ev));
    chk("issue_ready", 32'(xif.issue_ready), 32'(m_ready()));
    chk("count", 32'(dut.count_reg), 32'(mq.size()));
    if (xif.issue_valid) begin
      chk("accept", 32'(xif.issue_resp_accept), 32'(m_recog(xif.issue_req_instr)));
      chk("writeback", 32'(xif.issue_resp_writeback), 32'(m_recog(xif.issue_req_instr)));
      chk("resp_zero", 32'({xif.issue_resp_dualwrite, xif.issue_resp_dualread,
                            xif.issue_resp_loadstore, xif.issue_resp_exc}), 32'd0);
    end
    if (ev) begin
      chk("result_id", 32'(xif.result_id), 32'(mq[0].id));
      chk("result_rd", 32'(xif.result_rd), 32'(mq[0].rd));
      chk("result_data", xif.result_data, mq[0].data);
      chk("result_we", 32'(xif.result_we), 32'd1);
      chk("result_exc", 32'({xif.result_exc, xif.result_exccode}), 32'd0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) compare();
  end

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
    return {7'd0, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input int id, input logic [2:0] f3, input int rd,
                             input logic [31:0] a, input logic [31:0] b);
    xif.issue_valid        = 1'b1;
    xif.issue_req_instr    = mk_instr(f3, 5'(rd), 7'b0001011);
    xif.issue_req_rs[0]    = a;
    xif.issue_req_rs[1]    = b;
    xif.issue_req_rs_valid = 2'b11;
    xif.issue_req_id       = IDW'(id);
  endtask

  task automatic idle_issue();
    xif.issue_valid = 1'b0;
  endtask

  task automatic drive_commit(input int id, input bit kill);
    xif.commit_valid = 1'b1;
    xif.commit_id    = IDW'(id);
    xif.commit_kill  = kill;
  endtask

  task automatic idle_commit();
    xif.commit_valid = 1'b0;
  endtask

  // Wait (bounded) for a result and consume it; result_ready must already be 1
  task automatic expect_result(input int exp_id, input logic [31:0] exp_data);
    int n = 0;
    while (!xif.result_valid && n < 20) begin
      step();
      n++;
    end
    chk("exp_valid", 32'(xif.result_valid), 32'd1);
    chk("exp_id", 32'(xif.result_id), 32'(exp_id));
    chk("exp_data", xif.result_data, exp_data);
    step();
  endtask

  initial begin
    xif.issue_valid        = 1'b0;
    xif.issue_req_instr    = '0;
    xif.issue_req_rs       = '0;
    xif.issue_req_rs_valid = 2'b00;
    xif.issue_req_id       = '0;
    xif.commit_valid       = 1'b0;
    xif.commit_id          = '0;
    xif.commit_kill        = 1'b0;
    xif.result_ready       = 1'b0;

    // Reset state
    step();
    step();
    check_en = 1'b1;
    chk("rst_valid", 32'(xif.result_valid), 32'd0);
    chk("rst_count", 32'(dut.count_reg), 32'd0);
    chk("rst_ready", 32'(xif.issue_ready), 32'd0);
    chk("rst_data", xif.result_data, 32'd0);
    rst = 1'b0;
    xif.result_ready = 1'b1;
    step();

    // ADD 5+7, commit next cycle, result two cycles after issue
    drive_issue(1, 3'b000, 3, 32'd5, 32'd7);
    step();
    idle_issue();
    drive_commit(1, 1'b0);
    step();
    idle_commit();
    chk("add_valid", 32'(xif.result_valid), 32'd1);
    chk("add_id", 32'(xif.result_id), 32'd1);
    chk("add_rd", 32'(xif.result_rd), 32'd3);
    chk("add_data", xif.result_data, 32'd12);
    chk("add_we", 32'(xif.result_we), 32'd1);
    step();
    chk("add_popped", 32'(xif.result_valid), 32'd0);

    // Killed entry vanishes without a result
    drive_issue(2, 3'b000, 4, 32'd1, 32'd1);
    step();
    idle_issue();
    drive_commit(2, 1'b1);
    step();
    idle_commit();
    chk("kill_valid0", 32'(xif.result_valid), 32'd0);
    chk("kill_count1", 32'(dut.count_reg), 32'd1);
    step();
    chk("kill_valid1", 32'(xif.result_valid), 32'd0);
    chk("kill_count0", 32'(dut.count_reg), 32'd0);

    // Fill the queue, then probe a fifth recognised and an unrecognised instruction
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(4 + i, 3'b000, i + 1, 32'(i), 32'd100);
      step();
    end
    drive_issue(8, 3'b000, 5, 32'd1, 32'd2);
    #1;
    chk("full_ready", 32'(xif.issue_ready), 32'd0);
    chk("full_accept", 32'(xif.issue_resp_accept), 32'd1);
    xif.issue_req_instr    = mk_instr(3'b000, 5'd5, 7'b0110011);
    xif.issue_req_rs_valid = 2'b00;
    #1;
    chk("unrec_ready", 32'(xif.issue_ready), 32'd1);
    chk("unrec_accept", 32'(xif.issue_resp_accept), 32'd0);
    step();
    idle_issue();
    chk("full_count", 32'(dut.count_reg), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      drive_commit(4 + i, 1'b0);
      step();
    end
    idle_commit();
    repeat (6) step();
    chk("drain_count", 32'(dut.count_reg), 32'd0);

    // Wrap-around add, optional subtract
    drive_issue(9, 3'b000, 1, 32'hFFFF_FFFF, 32'd1);
    step();
    idle_issue();
    drive_commit(9, 1'b0);
    step();
    idle_commit();
    chk("wrap_valid", 32'(xif.result_valid), 32'd1);
    chk("wrap_data", xif.result_data, 32'd0);
    step();
    drive_issue(10, 3'b001, 2, 32'd0, 32'd1);
    #1;
`ifdef XIF_COPROC_SUB_EN
    chk("sub_accept", 32'(xif.issue_resp_accept), 32'd1);
    step();
    idle_issue();
    drive_commit(10, 1'b0);
    step();
    idle_commit();
    chk("sub_data", xif.result_data, 32'hFFFF_FFFF);
    step();
`else
    chk("sub_accept", 32'(xif.issue_resp_accept), 32'd0);
    step();
    idle_issue();
    step();
    chk("sub_count", 32'(dut.count_reg), 32'd0);
`endif

    // Out-of-order commits with a stalled consumer
    xif.result_ready = 1'b0;
    drive_issue(1, 3'b000, 1, 32'd10, 32'd20);
    step();
    drive_issue(2, 3'b000, 2, 32'd100, 32'd1);
    step();
    drive_issue(3, 3'b000, 3, 32'd7, 32'd8);
    step();
    idle_issue();
    drive_commit(3, 1'b0);
    step();
    drive_commit(1, 1'b0);
    step();
    drive_commit(2, 1'b0);
    step();
    idle_commit();
    repeat (5) step();
    chk("stall_valid", 32'(xif.result_valid), 32'd1);
    chk("stall_id", 32'(xif.result_id), 32'd1);
    chk("stall_data", xif.result_data, 32'd30);
    xif.result_ready = 1'b1;
    expect_result(1, 32'd30);
    expect_result(2, 32'd101);
    expect_result(3, 32'd15);
    chk("order_count", 32'(dut.count_reg), 32'd0);

    // Reset with committed entries pending
    xif.result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(11 + i, 3'b000, i + 1, 32'(i), 32'd1);
      step();
    end
    idle_issue();
    for (int i = 0; i < 3; i++) begin
      drive_commit(11 + i, 1'b0);
      step();
    end
    idle_commit();
    step();
    chk("pre_rst_valid", 32'(xif.result_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(xif.result_valid), 32'd0);
    chk("mid_rst_count", 32'(dut.count_reg), 32'd0);
    chk("mid_rst_ready", 32'(xif.issue_ready), 32'd0);
    rst = 1'b0;
    xif.result_ready = 1'b1;
    repeat (10) begin
      step();
      chk("post_rst_valid", 32'(xif.result_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
